icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_BITS, default 7, number of index bits; the cache holds 2^INDEX_BITS lines.
REQ-002 Parameter ADDR_LEN, default 32, width of address ports.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 rdy  input  1  global ready; low freezes all state and registered outputs.
REQ-006 if_request  input  1  fetch request from ifetch; held high until the cycle if_enable is seen.
REQ-007 if_addr  input  ADDR_LEN  fetch byte address; bits [1:0] ignored, bits [17:2] used.
REQ-008 if_inst  output  32  returned instruction word; valid only while if_enable is high.
REQ-009 if_enable  output  1  one-cycle pulse: if_inst valid.
REQ-010 failed  input  1  branch mispredict flush from ex.
REQ-011 mc_request  output  1  refill request to mem_ctrl; held until mc_enable.
REQ-012 mc_addr  output  ADDR_LEN  refill word address, {if_addr[ADDR_LEN-1:2], 2'b00}.
REQ-013 mc_inst  input  32  refill word from mem_ctrl, valid with mc_enable.
REQ-014 mc_enable  input  1  one-cycle pulse: mc_inst valid.

Function
REQ-015 The cache SHALL be direct-mapped, one 32-bit word per line; index = if_addr[INDEX_BITS+1:2]; tag = if_addr[17:INDEX_BITS+2]; one valid bit per line.
REQ-016 The FSM SHALL have states IDLE, MISS and RESP.
REQ-017 IDLE with if_request=1 and hit (valid and tag match) SHALL go to RESP next cycle, with if_inst loaded from the line and if_enable=1 in RESP; hit latency = 1 cycle.
REQ-018 IDLE with if_request=1 and miss SHALL go to MISS, latch index/tag, and assert mc_request with mc_addr from the next cycle.
REQ-019 MISS SHALL hold mc_request and mc_addr stable until mc_enable=1; on mc_enable it SHALL write data/tag, set valid, load if_inst=mc_inst, and go to RESP.
REQ-020 RESP SHALL last exactly one cycle with if_enable=1, then return to IDLE; a new lookup is accepted only in IDLE.
REQ-021 if_request=0 in IDLE SHALL leave the state IDLE with no memory traffic.
REQ-022 failed=1 in any state SHALL force IDLE next cycle, drop mc_request, and keep if_enable=0 that cycle and the next.
REQ-023 failed=1 in MISS SHALL cancel the line write; an mc_enable arriving in the same cycle as failed SHALL be discarded.
REQ-024 failed=1 in IDLE coinciding with if_request SHALL prevent the lookup from starting.
REQ-025 rdy=0 SHALL hold state, array contents, and all outputs; mc_enable is not sampled while rdy=0.
REQ-026 if_enable and mc_request SHALL never both be high in the same cycle.

Reset
REQ-027 On rst=0, state SHALL go to IDLE, all valid bits cleared, if_enable=0, mc_request=0, if_inst=0, mc_addr=0, counters=0, regardless of clk or rdy.
REQ-028 Release of rst mid-refill SHALL start cleanly in IDLE; a stale mc_enable in IDLE is ignored.

Configuration
REQ-029 Macro ICACHE_PERF_EN: when defined, add outputs hit_cnt (32) and miss_cnt (32), incremented on each IDLE->RESP hit and IDLE->MISS transition, both wrapping at 2^32, not incremented under failed or rdy=0.
REQ-030 Without ICACHE_PERF_EN, the counters and their ports SHALL be absent; function is otherwise identical.

Verification
REQ-031 Cold miss: reset, request 0x0000_1000 -> mc_request=1, mc_addr=0x1000 next cycle; mc_enable with mc_inst=0x0000_0013 -> if_enable=1, if_inst=0x13 one cycle later.
REQ-032 Hit: repeat 0x1000 -> if_enable=1 with 0x13 one cycle after request, mc_request stays 0.
REQ-033 Conflict: with INDEX_BITS=7, request 0x1200 (same index, new tag) -> miss/refill with 0xDEADBEEF; then 0x1000 -> misses again.
REQ-034 Flush: failed=1 in MISS coinciding with mc_enable -> IDLE, no if_enable, next request to the same address still misses.
REQ-035 Freeze: rdy=0 for 5 cycles during MISS -> mc_request/mc_addr unchanged; response completes after rdy=1.
REQ-036 Async reset: rst=0 mid-RESP between clock edges -> if_enable=0 immediately; with ICACHE_PERF_EN, hit_cnt=miss_cnt=0.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, refill FSM.
// Define ICACHE_PERF_EN to add hit_cnt/miss_cnt outputs.
module icache #(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_LEN   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                if_request,
  input  logic [ADDR_LEN-1:0] if_addr,
  output logic [31:0]         if_inst,
  output logic                if_enable,
  input  logic                failed,
  output logic                mc_request,
  output logic [ADDR_LEN-1:0] mc_addr,
  input  logic [31:0]         mc_inst,
`ifdef ICACHE_PERF_EN
  input  logic                mc_enable,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
`else
  input  logic                mc_enable
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 16 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [LINES-1:0]      valid_q, valid_d;
  logic [31:0]           data_q [LINES];
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [TAG_W-1:0]      mtag_q, mtag_d;
  logic [31:0]           inst_q, inst_d;
  logic                  en_q, en_d;
  logic                  req_q, req_d;
  logic [ADDR_LEN-1:0]   addr_q, addr_d;
  logic                  wr_en;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic                  unused_lsb;

  assign idx        = if_addr[INDEX_BITS+1:2];
  assign tag        = if_addr[17:INDEX_BITS+2];
  assign hit        = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_lsb = ^if_addr[1:0];

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    mtag_d  = mtag_q;
    inst_d  = inst_q;
    en_d    = en_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wr_en   = 1'b0;
    if (rdy) begin
      if (failed) begin
        state_d = IDLE;
        en_d    = 1'b0;
        req_d   = 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (if_request) begin
              if (hit) begin
                state_d = RESP;
                inst_d  = data_q[idx];
                en_d    = 1'b1;
              end else begin
                state_d = MISS;
                idx_d   = idx;
                mtag_d  = tag;
                req_d   = 1'b1;
                addr_d  = {if_addr[ADDR_LEN-1:2], 2'b00};
              end
            end
          end
          MISS: begin
            if (mc_enable) begin
              state_d        = RESP;
              wr_en          = 1'b1;
              valid_d[idx_q] = 1'b1;
              inst_d         = mc_inst;
              en_d           = 1'b1;
              req_d          = 1'b0;
            end
          end
          RESP: begin
            state_d = IDLE;
            en_d    = 1'b0;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      idx_q   <= '0;
      mtag_q  <= '0;
      inst_q  <= '0;
      en_q    <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      mtag_q  <= mtag_d;
      inst_q  <= inst_d;
      en_q    <= en_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  // Line storage needs no reset; valid bits guard it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[idx_q] <= mc_inst;
      tag_q[idx_q]  <= mtag_q;
    end
  end

  // A flush suppresses a response that is on the port this cycle.
  assign if_enable  = en_q & ~(failed & rdy);
  assign if_inst    = inst_q;
  assign mc_request = req_q;
  assign mc_addr    = addr_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (rdy && !failed && state_q == IDLE && if_request) begin
      if (hit) hit_cnt_d = hit_cnt_q + 32'd1;
      else     miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios plus random traffic
// checked every cycle against a transaction-level cache model.
module tb_icache;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic        if_request = 1'b0;
  logic        failed = 1'b0;
  logic        mc_enable = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] mc_inst = '0;
  logic [31:0] if_inst, mc_addr;
  logic        if_enable, mc_request;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  icache #(.INDEX_BITS(7), .ADDR_LEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .if_request(if_request),
    .if_addr(if_addr),
    .if_inst(if_inst),
    .if_enable(if_enable),
    .failed(failed),
    .mc_request(mc_request),
    .mc_addr(mc_addr),
    .mc_inst(mc_inst),
`ifdef ICACHE_PERF_EN
    .mc_enable(mc_enable),
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
`else
    .mc_enable(mc_enable)
`endif
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a cache of 128 one-word lines, tag = addr[17:9],
  // at most one outstanding refill and one pending response.
  bit          m_valid [128];
  logic [8:0]  m_tag   [128];
  logic [31:0] m_data  [128];
  bit          m_pend, m_deliv;
  logic [31:0] m_paddr, m_word;
  logic [31:0] m_hits, m_misses;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 128; k++) m_valid[k] <= 1'b0;
      m_pend   <= 1'b0;
      m_deliv  <= 1'b0;
      m_hits   <= '0;
      m_misses <= '0;
    end else if (rdy) begin
      if (failed) begin
        m_pend  <= 1'b0;
        m_deliv <= 1'b0;
      end else if (m_deliv) begin
        m_deliv <= 1'b0;
      end else if (m_pend) begin
        if (mc_enable) begin
          m_valid[m_paddr[8:2]] <= 1'b1;
          m_tag[m_paddr[8:2]]   <= m_paddr[17:9];
          m_data[m_paddr[8:2]]  <= mc_inst;
          m_word  <= mc_inst;
          m_deliv <= 1'b1;
          m_pend  <= 1'b0;
        end
      end else if (if_request) begin
        if (m_valid[if_addr[8:2]] && m_tag[if_addr[8:2]] == if_addr[17:9]) begin
          m_word  <= m_data[if_addr[8:2]];
          m_deliv <= 1'b1;
          m_hits  <= m_hits + 32'd1;
        end else begin
          m_pend   <= 1'b1;
          m_paddr  <= {if_addr[31:2], 2'b00};
          m_misses <= m_misses + 32'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_rst_en", {31'd0, if_enable}, 32'd0);
      chk("m_rst_req", {31'd0, mc_request}, 32'd0);
      chk("m_rst_inst", if_inst, 32'd0);
      chk("m_rst_addr", mc_addr, 32'd0);
    end else begin
      chk("m_en", {31'd0, if_enable}, {31'd0, m_deliv && !(failed && rdy)});
      chk("m_req", {31'd0, mc_request}, {31'd0, m_pend});
      if (m_pend) chk("m_addr", mc_addr, m_paddr);
      if (m_deliv) chk("m_inst", if_inst, m_word);
      chk("m_excl", {31'd0, if_enable & mc_request}, 32'd0);
    end
`ifdef ICACHE_PERF_EN
    chk("m_hits", hit_cnt, m_hits);
    chk("m_miss", miss_cnt, m_misses);
`endif
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = (32'($urandom_range(0, 7)) << 9)
      | (32'($urandom_range(0, 15)) << 2)
      | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0)
      a = a | (32'($urandom_range(1, 15)) << 18);
    return a;
  endfunction

  logic en_s;

  initial begin
    #1 rst = 1'b0;
    rdy = 1'b1;
    tick();
    tick();
    chk("rst_en", {31'd0, if_enable}, 32'd0);
    chk("rst_req", {31'd0, mc_request}, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_addr", mc_addr, 32'd0);
    rst = 1'b1;

    // cold miss
    if_request = 1'b1;
    if_addr = 32'h1000;
    tick();
    chk("cold_req", {31'd0, mc_request}, 32'd1);
    chk("cold_addr", mc_addr, 32'h1000);
    chk("cold_en0", {31'd0, if_enable}, 32'd0);
    mc_enable = 1'b1;
    mc_inst = 32'h13;
    tick();
    chk("cold_en", {31'd0, if_enable}, 32'd1);
    chk("cold_inst", if_inst, 32'h13);
    chk("cold_req0", {31'd0, mc_request}, 32'd0);
    if_request = 1'b0;
    mc_enable = 1'b0;
    tick();
    chk("cold_pulse", {31'd0, if_enable}, 32'd0);

    // hit
    if_request = 1'b1;
    tick();
    chk("hit_en", {31'd0, if_enable}, 32'd1);
    chk("hit_inst", if_inst, 32'h13);
    chk("hit_req", {31'd0, mc_request}, 32'd0);
    if_request = 1'b0;
    tick();

    // conflict on index 0
    if_request = 1'b1;
    if_addr = 32'h1200;
    tick();
    chk("conf_req", {31'd0, mc_request}, 32'd1);
    chk("conf_addr", mc_addr, 32'h1200);
    mc_enable = 1'b1;
    mc_inst = 32'hDEADBEEF;
    tick();
    chk("conf_inst", if_inst, 32'hDEADBEEF);
    if_request = 1'b0;
    mc_enable = 1'b0;
    tick();
    if_request = 1'b1;
    if_addr = 32'h1000;
    tick();
    chk("conf_remiss", {31'd0, mc_request}, 32'd1);
    mc_enable = 1'b1;
    mc_inst = 32'h13;
    tick();
    if_request = 1'b0;
    mc_enable = 1'b0;
    tick();

    // flush during refill
    if_request = 1'b1;
    if_addr = 32'h2000;
    tick();
    chk("fl_req", {31'd0, mc_request}, 32'd1);
    failed = 1'b1;
    mc_enable = 1'b1;
    mc_inst = 32'h55;
    tick();
    chk("fl_req0", {31'd0, mc_request}, 32'd0);
    chk("fl_en0", {31'd0, if_enable}, 32'd0);
    failed = 1'b0;
    mc_enable = 1'b0;
    if_request = 1'b0;
    tick();
    chk("fl_en1", {31'd0, if_enable}, 32'd0);
    if_request = 1'b1;
    tick();
    chk("fl_remiss", {31'd0, mc_request}, 32'd1);

    // freeze in MISS; mc_enable while frozen is ignored
    rdy = 1'b0;
    mc_enable = 1'b1;
    mc_inst = 32'h99;
    for (int i = 0; i < 5; i++) begin
      tick();
      mc_enable = 1'b0;
      chk("frz_req", {31'd0, mc_request}, 32'd1);
      chk("frz_addr", mc_addr, 32'h2000);
    end
    rdy = 1'b1;
    mc_enable = 1'b1;
    mc_inst = 32'h77;
    tick();
    chk("frz_en", {31'd0, if_enable}, 32'd1);
    chk("frz_inst", if_inst, 32'h77);
    mc_enable = 1'b0;
    if_request = 1'b0;

    // async reset mid-RESP
    #2 rst = 1'b0;
    #1;
    chk("ar_en", {31'd0, if_enable}, 32'd0);
    chk("ar_req", {31'd0, mc_request}, 32'd0);
`ifdef ICACHE_PERF_EN
    chk("ar_hit", hit_cnt, 32'd0);
    chk("ar_miss", miss_cnt, 32'd0);
`endif
    tick();
    rst = 1'b1;
    if_request = 1'b1;
    if_addr = 32'h1000;
    tick();
    chk("ar_cold", {31'd0, mc_request}, 32'd1);

    // reset released mid-refill, stale mc_enable
    if_request = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    mc_enable = 1'b1;
    mc_inst = 32'hBAD;
    tick();
    chk("st_en", {31'd0, if_enable}, 32'd0);
    chk("st_req", {31'd0, mc_request}, 32'd0);
    mc_enable = 1'b0;
    if_request = 1'b1;
    tick();
    chk("st_miss", {31'd0, mc_request}, 32'd1);
    mc_enable = 1'b1;
    mc_inst = 32'h13;
    tick();
    if_request = 1'b0;
    mc_enable = 1'b0;
    tick();

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      en_s = if_enable;
      @(posedge clk);
      #1;
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0;
        #1 rst = 1'b1;
      end
      if (en_s || failed) if_request = 1'b0;
      else if (!if_request && $urandom_range(0, 2) == 0) begin
        if_request = 1'b1;
        if_addr = rand_addr();
      end
      failed = ($urandom_range(0, 24) == 0);
      rdy = ($urandom_range(0, 6) != 0);
      mc_enable = mc_request ? ($urandom_range(0, 2) == 0)
                             : ($urandom_range(0, 39) == 0);
      mc_inst = $urandom();
    end
    failed = 1'b0;
    mc_enable = 1'b0;
    if_request = 1'b0;
    rdy = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
